// File: rtl/osd_menu_pkg.sv
// Shared types and constants for the OSD menu controller.
package osd_menu_pkg;

  typedef enum logic [1:0] {
    HIDDEN = 2'd0,
    NAV    = 2'd1,
    EDIT   = 2'd2
  } menu_state_t;

  localparam int N_BTN = 4;
  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int OK    = 2;
  localparam int MENU  = 3;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/osd_btn_debounce.sv
// One push-button: 2-flop synchroniser, frame-sampled debounce, press pulse.
module osd_btn_debounce #(
  parameter int DEB_FRAMES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic newframe,
  input  logic btn,
  output logic press
);

  logic       sync_p0, sync_p1;
  logic       level;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       flip;

  assign cnt_inc = cnt + 4'd1;
  assign flip    = (sync_p1 != level) && (cnt_inc == 4'(DEB_FRAMES));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= 4'd0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // only an accepted rising level is an event; releases are silent
      press   <= newframe && flip && sync_p1;
      if (newframe) begin
        if (sync_p1 == level) begin
          cnt <= 4'd0;
        end else if (flip) begin
          cnt   <= 4'd0;
          level <= sync_p1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/osd_menu_ctrl.sv
// OSD menu sequencer: button navigation, value editing, commit, and
// frame-stable shadow outputs for the renderer.
module osd_menu_ctrl
  import osd_menu_pkg::*;
#(
  parameter int N_ITEMS        = 4,
  parameter int VAL_W          = 8,
  parameter int MAX_VAL        = 255,
  parameter int INIT_VAL       = 128,
  parameter int DEB_FRAMES     = 3,
  parameter int TIMEOUT_FRAMES = 600,
  localparam int IDX_W         = idx_w(N_ITEMS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       newframe,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_ok,
  input  logic                       btn_menu,
  output logic                       menu_visible,
  output logic [IDX_W-1:0]           sel_item,
  output logic                       edit_mode,
  output logic [VAL_W-1:0]           exit_value,
  output logic [N_ITEMS*VAL_W-1:0]   cfg_values,
  output logic                       cfg_update
);

  localparam int TO_W = (TIMEOUT_FRAMES < 2) ? 1 : $clog2(TIMEOUT_FRAMES + 1);

  function automatic logic [VAL_W-1:0] sat_inc(input logic [VAL_W-1:0] v);
    return (v >= VAL_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : v + VAL_W'(1);
  endfunction

  function automatic logic [VAL_W-1:0] sat_dec(input logic [VAL_W-1:0] v);
    return (v == '0) ? '0 : v - VAL_W'(1);
  endfunction

  logic [N_BTN-1:0] btn_raw, press;
  menu_state_t      state, state_nxt;
  logic [IDX_W-1:0] sel, sel_nxt;
  logic [VAL_W-1:0] work_val [N_ITEMS];
  logic [VAL_W-1:0] backup, cur_val, val_wdata;
  logic [TO_W-1:0]  idle_cnt;
  logic             ev_menu, ev_ok, ev_up, ev_down, any_ev;
  logic             timeout_hit, to_ev;
  logic             val_wr, bkp_wr, commit;

  assign btn_raw[UP]   = btn_up;
  assign btn_raw[DOWN] = btn_down;
  assign btn_raw[OK]   = btn_ok;
  assign btn_raw[MENU] = btn_menu;

  for (genvar b = 0; b < N_BTN; b++) begin : g_deb
    osd_btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .newframe (newframe),
      .btn      (btn_raw[b]),
      .press    (press[b])
    );
  end

  // strict priority menu > ok > up > down
  assign ev_menu = press[MENU];
  assign ev_ok   = press[OK]   && !press[MENU];
  assign ev_up   = press[UP]   && !press[MENU] && !press[OK];
  assign ev_down = press[DOWN] && !press[MENU] && !press[OK] && !press[UP];
  assign any_ev  = |press;
  assign cur_val = work_val[sel];

  assign timeout_hit = (TIMEOUT_FRAMES != 0) && newframe && (state != HIDDEN) &&
                       (idle_cnt == TO_W'(TIMEOUT_FRAMES - 1));
  assign to_ev       = timeout_hit && !any_ev;

  always_ff @(posedge clk) begin
    if (!rst) state <= HIDDEN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HIDDEN: if (ev_menu) state_nxt = NAV;
      NAV: begin
        if (ev_menu || to_ev) state_nxt = HIDDEN;
        else if (ev_ok)       state_nxt = EDIT;
      end
      EDIT: begin
        if (ev_ok || ev_menu) state_nxt = NAV;
        else if (to_ev)       state_nxt = HIDDEN;
      end
      default: state_nxt = HIDDEN;
    endcase
  end

  always_comb begin
    sel_nxt   = sel;
    val_wr    = 1'b0;
    val_wdata = cur_val;
    bkp_wr    = 1'b0;
    commit    = 1'b0;
    case (state)
      HIDDEN: if (ev_menu) sel_nxt = '0;
      NAV: begin
        if (ev_ok)        bkp_wr  = 1'b1;
        else if (ev_up)   sel_nxt = (sel == '0) ? IDX_W'(N_ITEMS - 1) : sel - IDX_W'(1);
        else if (ev_down) sel_nxt = (sel == IDX_W'(N_ITEMS - 1)) ? '0 : sel + IDX_W'(1);
      end
      EDIT: begin
        // timeout out of EDIT is a cancel, same as menu
        if (ev_ok) begin
          commit = 1'b1;
        end else if (ev_menu || to_ev) begin
          val_wr    = 1'b1;
          val_wdata = backup;
        end else if (ev_up) begin
          val_wr    = 1'b1;
          val_wdata = sat_inc(cur_val);
        end else if (ev_down) begin
          val_wr    = 1'b1;
          val_wdata = sat_dec(cur_val);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sel        <= '0;
      backup     <= VAL_W'(INIT_VAL);
      for (int i = 0; i < N_ITEMS; i++) work_val[i] <= VAL_W'(INIT_VAL);
      cfg_values <= {N_ITEMS{VAL_W'(INIT_VAL)}};
      cfg_update <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      sel        <= sel_nxt;
      if (bkp_wr) backup <= cur_val;
      if (val_wr) work_val[sel] <= val_wdata;
      cfg_update <= commit;
      if (commit) cfg_values[sel*VAL_W +: VAL_W] <= cur_val;
      if ((state == HIDDEN) || any_ev || timeout_hit) idle_cnt <= '0;
      else if (newframe)                               idle_cnt <= idle_cnt + TO_W'(1);
    end
  end

  // shadow stage: renderer-facing state moves only at frame start
  always_ff @(posedge clk) begin
    if (!rst) begin
      menu_visible <= 1'b0;
      sel_item     <= '0;
      edit_mode    <= 1'b0;
      exit_value   <= VAL_W'(INIT_VAL);
    end else if (newframe) begin
      menu_visible <= (state != HIDDEN);
      sel_item     <= sel;
      edit_mode    <= (state == EDIT);
      exit_value   <= cur_val;
    end
  end

endmodule

// File: doc/osd_menu_ctrl.md
Name: osd_menu_ctrl

Overview:
- Control/sequencing block for the on-screen text overlay renderer.
- Turns four raw push-buttons into menu navigation and value editing.
- Owns the menu parameter registers.
- Presents frame-stable display state (visibility, selected row, edit flag, displayed value) to the renderer, plus committed configuration values to the video datapath.
- Display state changes only at frame boundaries, so the renderer never tears mid-frame.

Parameters:
- N_ITEMS, 4: number of menu rows (2..8).
- VAL_W, 8: width of each item value.
- MAX_VAL, 255: saturation ceiling for edited values (must be < 2**VAL_W).
- INIT_VAL, 128: reset value of every item.
- DEB_FRAMES, 3: consecutive equal frame samples needed to accept a button level (1..15).
- TIMEOUT_FRAMES, 600: idle frames before auto-hide (0 disables).

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: synchronous reset, active-low.
- newframe, in, 1: one-cycle pulse at frame start, synchronous to clk.
- btn_up, in, 1: raw button, active-high, asynchronous.
- btn_down, in, 1: raw button, active-high, asynchronous.
- btn_ok, in, 1: raw button, active-high, asynchronous.
- btn_menu, in, 1: raw button, active-high, asynchronous.
- menu_visible, out, 1: shadowed; renderer draws the window when 1.
- sel_item, out, IDX_W=clog2(N_ITEMS): shadowed highlighted row.
- edit_mode, out, 1: shadowed; selected row is being edited.
- exit_value, out, VAL_W: shadowed working value of the selected row.
- cfg_values, out, N_ITEMS*VAL_W: committed values; item i at [i*VAL_W +: VAL_W].
- cfg_update, out, 1: one-cycle pulse when cfg_values changes.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State HIDDEN, sel=0, all working and committed values = INIT_VAL.
  - Debounce counters and levels cleared; idle counter cleared.
  - Outputs: menu_visible=0, sel_item=0, edit_mode=0, exit_value=INIT_VAL, cfg_values=all INIT_VAL, cfg_update=0.
  - Reset mid-edit discards the edit; no cfg_update is issued.
- Input synchronisation: each button passes through a 2-flop synchroniser.
- Debounce:
  - Sampled only on newframe cycles.
  - The per-button counter increments while sample != accepted level and clears when equal.
  - On reaching DEB_FRAMES, the level flips and the counter clears.
  - Accepted 0->1 transition produces a press event, registered, high exactly one cycle (the cycle after newframe). Release produces no event.
- Event priority within the same cycle: menu > ok > up > down. Only the highest-priority event acts; the others are dropped.
- FSM (updates on event cycles):
  - HIDDEN: menu -> NAV with sel=0. Other events are ignored.
  - NAV:
    - up: sel-1, wrapping 0 -> N_ITEMS-1.
    - down: sel+1, wrapping N_ITEMS-1 -> 0.
    - ok: save the working value of sel into backup, then -> EDIT.
    - menu: -> HIDDEN.
  - EDIT:
    - up: value+1, saturating at MAX_VAL.
    - down: value-1, saturating at 0.
    - ok: copy working value into cfg_values[sel], pulse cfg_update the next cycle, then -> NAV.
    - menu: restore backup into the working value, then -> NAV, with no cfg_update.
- Idle timeout:
  - Counter increments on each newframe while not HIDDEN; clears on any event.
  - On reaching TIMEOUT_FRAMES, state -> HIDDEN. From EDIT this is treated as a cancel: backup restored, no commit.
  - If a timeout and an event land on the same cycle, the event wins.
- Shadow registers:
  - menu_visible, sel_item, edit_mode and exit_value load from working state only on a newframe cycle; they hold otherwise.
  - An event at frame k (one cycle after newframe) therefore appears on the shadow outputs one cycle after newframe of frame k+1.
- cfg_values is not shadowed. It updates on the commit cycle.

Decomposition:
- Shared package osd_menu_pkg, containing:
  - menu state enum (HIDDEN, NAV, EDIT);
  - button index constants (UP, DOWN, OK, MENU);
  - clog2-based IDX_W helper.
- Sub-module osd_btn_debounce: synchroniser, frame-sampled debounce counter and press-event generator; four instances.

Test Plan:
- Reset: hold rst=0 for 3 cycles with buttons toggling -> all outputs at reset values, cfg_update never 1, cfg_values all 8'd128.
- Open and navigate: press menu for 3 frames -> menu_visible=1 from frame 4. Then press up once -> sel_item=3 (wrap), exit_value=128.
- Edit and commit: in NAV, ok, then up held 3 frames, released, and pressed again with full debounce -> exactly one increment per accepted press. Then ok -> cfg_values[sel]=130 and a single cfg_update pulse.
- Saturation and cancel:
  - edit an item at 255 and press up -> stays 255;
  - edit at 0 and press down -> stays 0;
  - edit to 5, then menu -> value restored, cfg_values unchanged, edit_mode=0.
- Glitch and simultaneous events: a 2-frame bounce on btn_up -> no event. menu and up accepted in the same frame while in NAV -> HIDDEN, sel unchanged.
- Timeout and tearing: with TIMEOUT_FRAMES=5, enter EDIT, change the value and idle 5 frames -> HIDDEN, value restored. Also assert that the shadow outputs never change on a cycle without newframe.
